param_register_file: RTL
========================

# param_register_file

Parametrised, multi-ported general-purpose register file for the datapath: one write port and three independent read ports (A, B and D operands) that can all be used in the same cycle. Reads are registered with one-cycle latency. A hardware initialisation sweep rewrites every register without a reset, and optional write-to-read forwarding is selected at compile time. It sits between the instruction decoder (addresses and enables) and the ALU/writeback stage (operands and result).

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH registers
- INIT_ZERO, 0, init value select: 0 = each register loads its own index (truncated to DATA_WIDTH); 1 = all zero
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- we  input  1  write enable
- wa  input  ADDR_WIDTH  write address
- wd  input  DATA_WIDTH  write data
- re  input  1  read enable, common to all three read ports
- ra_a, ra_b, ra_d  input  ADDR_WIDTH each  read addresses for ports A, B, D
- rd_a, rd_b, rd_d  output  DATA_WIDTH each  registered read data
- init_req  input  1  single-cycle request to start the init sweep
- busy  output  1  high while the sweep runs
- init_done  output  1  one-cycle pulse when the sweep completes

## Operation
- Reset asserted (low), taking effect immediately without waiting for clk:
  - every register is loaded with its init value (per INIT_ZERO)
  - rd_a/rd_b/rd_d = 0, busy = 0, init_done = 0, FSM = IDLE, sweep counter = 0
- Write: in IDLE with we=1, regs[wa] <= wd at the clock edge.
- Read: in IDLE with re=1, each rd_x <= regs[ra_x] at the clock edge. With re=0, all outputs hold their value.
- Reads and writes are independent. Read, write and all three ports may be active in the same cycle. Identical read addresses on several ports are legal.
- Read of wa in the same cycle as the write:
  - without forwarding, the output returns the old contents
  - with forwarding, see Configuration
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on init_req=1. The counter clears to 0.
  - SWEEP: each cycle regs[cnt] <= init value(cnt) and cnt increments. After the cycle that writes cnt = DEPTH-1, go to DONE.
  - DONE: init_done=1 for exactly one cycle, then IDLE.
- busy=1 in SWEEP and DONE.
- While busy:
  - we and re are ignored and the outputs hold
  - init_req is ignored; no restart, no queueing
- init_req and we asserted in the same IDLE cycle: the write is performed and the sweep starts next cycle, so the sweep overwrites the written value.
- Counter is ADDR_WIDTH+1 bits wide so the terminal count never aliases. Init value is the index zero-extended, or truncated, to DATA_WIDTH.
- Reset during SWEEP or DONE aborts the sweep immediately. No init_done pulse is produced.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives data valid after edge N.
- Write visible to a non-forwarded read issued in cycle N+1 or later.
- Sweep: init_req sampled at edge 0. busy rises after edge 0. DEPTH write cycles follow, then 1 DONE cycle. busy falls after edge DEPTH+1, so busy is high for DEPTH+1 cycles.
- First normal access is accepted in the cycle in which busy is low.
- Reset release is synchronous to the design's usage. reset deassertion must meet recovery/removal relative to clk.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read port whose address equals wa, with we=1 in the same IDLE cycle, returns wd instead of the stored value
  - applies independently to each of the three ports
  - no forwarding while busy
- Not defined: no forwarding logic is compiled in; same-cycle read of wa returns the old value.
- The macro only changes the result of a same-address read in the same cycle. Write and sweep timing are the same in both builds.

## Test plan
- Reset, INIT_ZERO=0, DATA_WIDTH=16, ADDR_WIDTH=4: assert reset low mid-cycle. Outputs go to 0 with no clk edge. Then re=1 with ra_a=3, ra_b=15, ra_d=0 returns 0x0003/0x000F/0x0000 one cycle later.
- Concurrent access: we=1, wa=5, wd=0xBEEF in cycle N; re=1, ra_a=5 in cycle N+1. rd_a=0xBEEF after edge N+1. In the same cycle ra_b=ra_d=7 both return 0x0007.
- Same-cycle hazard: we=1, wa=9, wd=0x1234, re=1, ra_a=9. With REGFILE_BYPASS_EN rd_a=0x1234; without it rd_a=0x0009. The next-cycle read returns 0x1234 in both builds.
- Sweep: write 0xFFFF to all 16 registers, set INIT_ZERO=1, then pulse init_req. busy is high for 17 cycles and init_done pulses once. Writes attempted during busy are dropped. Reads afterwards return 0x0000 everywhere.
- Abort: pulse init_req, then assert reset after 6 sweep cycles. busy=0 immediately, no init_done pulse, and all registers hold their reset init values.
- re=0 hold: read ra_a=2 (0x0002), then drop re and change ra_a=4 while writing wa=2. rd_a stays 0x0002 for the cycles re remains low.

Source files
------------

// File: rtl/param_register_file.sv
// Multi-ported register file: one write port, three registered read ports,
// and a hardware init sweep. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module param_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int INIT_ZERO  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra_a,
  input  logic [ADDR_WIDTH-1:0] ra_b,
  input  logic [ADDR_WIDTH-1:0] ra_d,
  output logic [DATA_WIDTH-1:0] rd_a,
  output logic [DATA_WIDTH-1:0] rd_b,
  output logic [DATA_WIDTH-1:0] rd_d,
  input  logic                  init_req,
  output logic                  busy,
  output logic                  init_done,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int NPORT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  sweep_wr;
  logic                  wr_en;
  logic                  rd_en;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [ADDR_WIDTH-1:0] ra      [NPORT];
  logic [DATA_WIDTH-1:0] rd_next [NPORT];
  logic [DATA_WIDTH-1:0] rd_q    [NPORT];

  // Index zero-extended or truncated to the register width, or zero.
  function automatic logic [DATA_WIDTH-1:0] init_value(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] wide;
    wide = '0;
    wide[ADDR_WIDTH-1:0] = idx;
    if (INIT_ZERO != 0) return '0;
    return wide[DATA_WIDTH-1:0];
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sweep_wr   = 1'b0;
    busy       = 1'b0;
    init_done  = 1'b0;
    case (state)
      IDLE: begin
        if (init_req) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        busy     = 1'b1;
        sweep_wr = 1'b1;
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(DEPTH - 1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        init_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;
  // Normal accesses are only honoured in IDLE; everything is frozen while busy.
  assign wr_en = (state == IDLE) && we;
  assign rd_en = (state == IDLE) && re;

  // ---------------- storage ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= init_value(ADDR_WIDTH'(i));
    end else if (sweep_wr) begin
      regs[cnt[ADDR_WIDTH-1:0]] <= init_value(cnt[ADDR_WIDTH-1:0]);
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // ---------------- read ports ----------------
  assign ra[0] = ra_a;
  assign ra[1] = ra_b;
  assign ra[2] = ra_d;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_next[p] = regs[ra[p]];
`ifdef REGFILE_BYPASS_EN
      // Same-cycle write to the address being read returns the new data.
      if (wr_en && (ra[p] == wa)) rd_next[p] = wd;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) rd_q[p] <= '0;
    end else if (rd_en) begin
      for (int p = 0; p < NPORT; p++) rd_q[p] <= rd_next[p];
    end
  end

  assign rd_a = rd_q[0];
  assign rd_b = rd_q[1];
  assign rd_d = rd_q[2];

endmodule
